dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the single-port synchronous data memory of the SoC. It shares the memory between the CPU data port and a DMA/debug port, and raises a stall to the CPU while its access is pending. DMA bursts are locked, but fairness to the CPU is bounded. The block sits between the CPU/DMA masters and the data memory instance.

---
 rtl/dmem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous data memory between the
// CPU data port and a DMA/debug port. Every access takes two cycles: an issue
// cycle in IDLE, then an ack cycle in which read data is passed straight from
// the memory. A locked DMA burst may hold the memory, but after MAX_BURST
// consecutive locked beats one pending CPU access is forced in.
module dmem_arbiter #(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int MAX_BURST = 4
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic          c_ack,
   output logic [DW-1:0] c_rdata,
   output logic          c_stall,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   input  logic          d_last,
   output logic          d_ack,
   output logic [DW-1:0] d_rdata,
   output logic          m_en,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata
);

   localparam int             CW      = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_BURST);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      C_WAIT = 2'd1,
      D_WAIT = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;

   // last_gnt: 1 = DMA was granted last, 0 = CPU was granted last
   logic          last_gnt;
   logic          lock;
   logic [CW-1:0] cnt;
   // direction of the access issued in the previous cycle
   logic          we_p1;

   logic          gnt_c;
   logic          gnt_d;

   // Beat counter increment that sticks at MAX_BURST
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      if (v == CNT_MAX) begin
         return v;
      end
      return v + CW'(1);
   endfunction

   // State register; an asynchronous reset abandons any access in flight
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Winner selection among the requests presented in IDLE
   always_comb begin
      gnt_c = 1'b0;
      gnt_d = 1'b0;
      if (state == IDLE) begin
         if (lock) begin
            if ((cnt == CNT_MAX) && c_req) begin
               gnt_c = 1'b1;
            end else if (d_req) begin
               gnt_d = 1'b1;
            end else if (c_req) begin
               gnt_c = 1'b1;
            end
         end else if (c_req && d_req) begin
            if (last_gnt) begin
               gnt_c = 1'b1;
            end else begin
               gnt_d = 1'b1;
            end
         end else if (c_req) begin
            gnt_c = 1'b1;
         end else if (d_req) begin
            gnt_d = 1'b1;
         end
      end
   end

   // Next state: an issue always moves to the owner's wait state, which always returns to IDLE
   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE: begin
            if (gnt_c) begin
               state_nxt = C_WAIT;
            end else if (gnt_d) begin
               state_nxt = D_WAIT;
            end
         end
         C_WAIT:  state_nxt = IDLE;
         D_WAIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Arbitration history: round-robin pointer, DMA burst lock and locked-beat count
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         last_gnt <= 1'b1;
         lock     <= 1'b0;
         cnt      <= '0;
         we_p1    <= 1'b0;
      end else if (gnt_d) begin
         last_gnt <= 1'b1;
         lock     <= ~d_last;
         cnt      <= d_last ? '0 : sat_inc(cnt);
         we_p1    <= d_we;
      end else if (gnt_c) begin
         last_gnt <= 1'b0;
         we_p1    <= c_we;
         // a CPU grant under lock at the limit is the forced fairness slot
         if (lock && (cnt == CNT_MAX)) begin
            cnt <= '0;
         end
      end
   end

   // Outputs: memory strobe in the issue cycle, owner ack and read data in the wait cycle
   always_comb begin
      m_en    = 1'b0;
      m_we    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      c_ack   = 1'b0;
      c_rdata = '0;
      d_ack   = 1'b0;
      d_rdata = '0;
      if (resetn) begin
         case (state)
            IDLE: begin
               if (gnt_c) begin
                  m_en    = 1'b1;
                  m_we    = c_we;
                  m_addr  = c_addr;
                  m_wdata = c_wdata;
               end else if (gnt_d) begin
                  m_en    = 1'b1;
                  m_we    = d_we;
                  m_addr  = d_addr;
                  m_wdata = d_wdata;
               end
            end
            C_WAIT: begin
               c_ack   = 1'b1;
               c_rdata = we_p1 ? '0 : m_rdata;
            end
            D_WAIT: begin
               d_ack   = 1'b1;
               d_rdata = we_p1 ? '0 : m_rdata;
            end
            default: begin
               m_en = 1'b0;
            end
         endcase
      end
      c_stall = c_req & ~c_ack;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed CPU/DMA request sequences, a small
// behavioural memory, and a transaction-level model of the arbitration rules
// checked against every DUT output each cycle.
module tb_dmem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MB = 4;

   logic          clock = 1'b0;
   logic          resetn;
   logic          c_req, c_we, c_ack, c_stall;
   logic [AW-1:0] c_addr;
   logic [DW-1:0] c_wdata, c_rdata;
   logic          d_req, d_we, d_last, d_ack;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata, d_rdata;
   logic          m_en, m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;

   dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
      .clock(clock), .resetn(resetn),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_ack(c_ack), .c_rdata(c_rdata), .c_stall(c_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_last(d_last), .d_ack(d_ack), .d_rdata(d_rdata),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata)
   );

   always #5 clock = ~clock;

   // memory instance: write commits at the issue edge, read data valid the next cycle
   logic [DW-1:0] mem [0:63];
   always @(posedge clock) begin
      if (m_en && !m_we) begin
         m_rdata <= mem[m_addr[7:2]];
      end else begin
         if (m_en) begin
            mem[m_addr[7:2]] <= m_wdata;
         end
         m_rdata <= 32'hA5A5_5A5A;
      end
   end

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        last;
      int          gap;
   } item_t;

   item_t cq[$];
   item_t dq[$];

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // model state
   bit          o_v;
   int          o_port;
   logic        o_we;
   logic [31:0] o_rd;
   bit          pol_lock;
   int          pol_beats;
   bit          pol_last_d;

   bit          c_ack_s, d_ack_s;
   byte         log_port[$];
   int          log_cyc[$];
   int          cack_cyc[$];
   int          dack_cyc[$];
   logic [31:0] crd_log[$];
   int          stall_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // 0 = no issue, 1 = CPU, 2 = DMA
   function automatic int pick();
      if (pol_lock) begin
         if (c_req && pol_beats >= MB) return 1;
         if (d_req) return 2;
         if (c_req) return 1;
         return 0;
      end
      if (c_req && d_req) return pol_last_d ? 1 : 2;
      if (c_req) return 1;
      if (d_req) return 2;
      return 0;
   endfunction

   task automatic check();
      logic        e_men, e_mwe, e_cack, e_dack, e_stall;
      logic [31:0] e_maddr, e_mwdata, e_crd, e_drd;
      int          w;
      e_men = 0; e_mwe = 0; e_cack = 0; e_dack = 0;
      e_maddr = 0; e_mwdata = 0; e_crd = 0; e_drd = 0;
      if (!resetn) begin
         o_v = 0; pol_lock = 0; pol_beats = 0; pol_last_d = 1;
      end else if (o_v) begin
         if (o_port == 1) begin
            e_cack = 1; e_crd = o_we ? 32'h0 : o_rd;
         end else begin
            e_dack = 1; e_drd = o_we ? 32'h0 : o_rd;
         end
         o_v = 0;
      end else begin
         w = pick();
         if (w == 1) begin
            e_men = 1; e_mwe = c_we; e_maddr = c_addr; e_mwdata = c_wdata;
            if (pol_lock && pol_beats >= MB) pol_beats = 0;
            pol_last_d = 0;
            log_port.push_back(8'h43);
         end else if (w == 2) begin
            e_men = 1; e_mwe = d_we; e_maddr = d_addr; e_mwdata = d_wdata;
            pol_lock = !d_last;
            if (d_last) pol_beats = 0; else pol_beats++;
            pol_last_d = 1;
            log_port.push_back(8'h44);
         end
         if (w != 0) begin
            o_v = 1; o_port = w; o_we = e_mwe; o_rd = mem[e_maddr[7:2]];
            log_cyc.push_back(cyc);
         end
      end
      e_stall = c_req & ~e_cack;
      chk("m_en", m_en, e_men);
      chk("m_we", m_we, e_mwe);
      chk("m_addr", m_addr, e_maddr);
      chk("m_wdata", m_wdata, e_mwdata);
      chk("c_ack", c_ack, e_cack);
      chk("d_ack", d_ack, e_dack);
      chk("c_rdata", c_rdata, e_crd);
      chk("d_rdata", d_rdata, e_drd);
      chk("c_stall", c_stall, e_stall);
      c_ack_s = c_ack;
      d_ack_s = d_ack;
      if (c_ack) begin
         cack_cyc.push_back(cyc);
         crd_log.push_back(c_rdata);
      end
      if (d_ack) dack_cyc.push_back(cyc);
      if (c_stall) stall_cnt++;
   endtask

   task automatic drive();
      item_t it;
      if (c_req && c_ack_s) c_req = 0;
      if (!c_req && cq.size() > 0) begin
         it = cq[0];
         if (it.gap == 0) begin
            void'(cq.pop_front());
            c_req = 1; c_we = it.we; c_addr = it.addr; c_wdata = it.wdata;
         end else begin
            it.gap = it.gap - 1;
            cq[0] = it;
         end
      end
      if (d_req && d_ack_s) d_req = 0;
      if (!d_req && dq.size() > 0) begin
         it = dq[0];
         if (it.gap == 0) begin
            void'(dq.pop_front());
            d_req = 1; d_we = it.we; d_addr = it.addr; d_wdata = it.wdata; d_last = it.last;
         end else begin
            it.gap = it.gap - 1;
            dq[0] = it;
         end
      end
   endtask

   task automatic cycle();
      @(negedge clock);
      check();
      @(posedge clock);
      cyc++;
      #1;
      drive();
   endtask

   task automatic addc(input logic we, input logic [31:0] a, input logic [31:0] wd, input int gap);
      item_t it;
      it.we = we; it.addr = a; it.wdata = wd; it.last = 1'b1; it.gap = gap;
      cq.push_back(it);
   endtask

   task automatic addd(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic last, input int gap);
      item_t it;
      it.we = we; it.addr = a; it.wdata = wd; it.last = last; it.gap = gap;
      dq.push_back(it);
   endtask

   task automatic clear_logs();
      log_port.delete(); log_cyc.delete(); cack_cyc.delete();
      dack_cyc.delete(); crd_log.delete(); stall_cnt = 0;
   endtask

   task automatic do_reset();
      resetn = 0;
      cycle();
      cycle();
      resetn = 1;
      clear_logs();
   endtask

   task automatic drain(input int maxc);
      int n;
      n = 0;
      while (!(cq.size() == 0 && dq.size() == 0 && !c_req && !d_req && !o_v) && n < maxc) begin
         cycle();
         n++;
      end
      chk("drain_in_budget", (n < maxc), 1'b1);
   endtask

   task automatic check_order(input string name, input string exp);
      chk({name, "_count"}, log_port.size(), exp.len());
      for (int i = 0; i < exp.len(); i++) begin
         if (i < log_port.size()) chk({name, "_port"}, log_port[i], exp[i]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rel_cyc;
      resetn = 0;
      c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
      d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_last = 0;
      o_v = 0; pol_lock = 0; pol_beats = 0; pol_last_d = 1;
      c_ack_s = 0; d_ack_s = 0;
      clear_logs();

      // reset with both ports requesting
      addc(1'b0, 32'h40, 32'h0, 0);
      addd(1'b1, 32'h80, 32'h1111_2222, 1'b1, 0);
      cycle();
      cycle();
      #1;
      chk("rst_m_en", m_en, 1'b0);
      chk("rst_m_addr", m_addr, 32'h0);
      chk("rst_m_wdata", m_wdata, 32'h0);
      chk("rst_c_stall", c_stall, 1'b1);
      chk("rst_c_ack", c_ack, 1'b0);
      resetn = 1;
      #1;
      chk("first_issue_m_en", m_en, 1'b1);
      chk("first_issue_addr", m_addr, 32'h40);
      drain(20);
      check_order("first_tie", "CD");

      // CPU write then read of the same word
      do_reset();
      addc(1'b1, 32'h10, 32'hDEAD_BEEF, 0);
      addc(1'b0, 32'h10, 32'h0, 0);
      drain(20);
      check_order("cpu_wr_rd", "CC");
      if (cack_cyc.size() == 2 && log_cyc.size() == 2) begin
         chk("cpu_wr_ack_lat", cack_cyc[0] - log_cyc[0], 1);
         chk("cpu_rd_ack_lat", cack_cyc[1] - log_cyc[1], 1);
         chk("cpu_wr_rdata", crd_log[0], 32'h0);
         chk("cpu_rd_rdata", crd_log[1], 32'hDEAD_BEEF);
      end else begin
         chk("cpu_ack_count", cack_cyc.size(), 2);
      end
      chk("cpu_stall_cycles", stall_cnt, 2);

      // round robin, both ports always requesting single-beat accesses
      do_reset();
      for (int i = 0; i < 4; i++) begin
         addc(1'b0, 32'h10, 32'h0, 0);
         addd(1'b1, 32'h60 + 4 * i, 32'h5000 + i, 1'b1, 0);
      end
      drain(40);
      check_order("rr", "CDCDCDCD");
      if (cack_cyc.size() == 4 && dack_cyc.size() == 4) begin
         for (int i = 0; i < 3; i++) begin
            chk("rr_c_spacing", cack_cyc[i + 1] - cack_cyc[i], 4);
            chk("rr_d_spacing", dack_cyc[i + 1] - dack_cyc[i], 4);
         end
      end else begin
         chk("rr_ack_count", cack_cyc.size() + dack_cyc.size(), 8);
      end

      // 9-beat locked burst with the CPU forced in after every MAX_BURST beats
      do_reset();
      for (int i = 0; i < 9; i++) begin
         addd(i[0], 32'h80 + 4 * i, 32'h9000 + i, (i == 8), 0);
      end
      addc(1'b0, 32'h80, 32'h0, 1);
      addc(1'b1, 32'hC0, 32'h1234_5678, 0);
      drain(60);
      check_order("burst", "DDDDCDDDDCD");
      // lock must be gone: a fresh tie goes to the CPU
      addc(1'b0, 32'hC0, 32'h0, 0);
      addd(1'b0, 32'h84, 32'h0, 1'b1, 0);
      drain(20);
      check_order("burst_unlock", "DDDDCDDDDCDCD");
      if (crd_log.size() == 3) chk("burst_c_rd", crd_log[2], 32'h1234_5678);

      // lock held across a DMA request gap
      do_reset();
      addd(1'b1, 32'h20, 32'hAAAA_0001, 1'b0, 0);
      addd(1'b1, 32'h24, 32'hAAAA_0002, 1'b1, 4);
      addc(1'b1, 32'h28, 32'hCCCC_0001, 1);
      addc(1'b1, 32'h2C, 32'hCCCC_0002, 0);
      addc(1'b0, 32'h20, 32'h0, 0);
      drain(40);
      check_order("lock_gap", "DCCDC");
      if (crd_log.size() == 3) chk("lock_gap_rd", crd_log[2], 32'hAAAA_0001);

      // reset while a DMA read waits for its ack
      do_reset();
      addd(1'b0, 32'h30, 32'h0, 1'b1, 0);
      addc(1'b1, 32'h34, 32'h7777_0000, 1);
      cycle();
      cycle();
      resetn = 0;
      #1;
      chk("midrst_d_ack", d_ack, 1'b0);
      chk("midrst_c_stall", c_stall, 1'b1);
      cycle();
      cycle();
      chk("midrst_no_d_ack", dack_cyc.size(), 0);
      resetn = 1;
      rel_cyc = cyc;
      #1;
      chk("midrst_issue_en", m_en, 1'b1);
      chk("midrst_issue_addr", m_addr, 32'h34);
      drain(20);
      check_order("midrst", "DCD");
      if (log_cyc.size() == 3) chk("midrst_c_issue_cycle", log_cyc[1], rel_cyc);
      chk("midrst_d_ack_count", dack_cyc.size(), 1);

      cycle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
